// File: rtl/tpu_ctrl_pkg.sv
// Shared constants for the HPS-driven TPU job controller: FSM encoding and
// the bit map of the status word presented to the HPS input PIO.
package tpu_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_LAUNCH  = 3'd1;
  localparam logic [STATE_W-1:0] ST_RUN     = 3'd2;
  localparam logic [STATE_W-1:0] ST_DONE    = 3'd3;
  localparam logic [STATE_W-1:0] ST_ERROR   = 3'd4;
  localparam logic [STATE_W-1:0] ST_RELEASE = 3'd5;

  localparam int unsigned STAT_W    = 2;
  localparam int unsigned STAT_DONE = 0;
  localparam int unsigned STAT_ERR  = 1;

endpackage : tpu_ctrl_pkg

// File: rtl/rise_edge_det.sv
// Registered rising-edge detector for HPS PIO command bits. An input held
// high through reset is not reported until it has been observed low.
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_q,   din_d;
  logic armed_q, armed_d;
  logic rise_q,  rise_d;

  always_comb begin
    din_d   = din;
    armed_d = armed_q | ~din;
    rise_d  = din & ~din_q & armed_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q   <= 1'b0;
      armed_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      din_q   <= din_d;
      armed_q <= armed_d;
      rise_q  <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule : rise_edge_det

// File: rtl/tpu_hps_job_ctrl.sv
// Runs one TPU job per HPS start edge, guards it with a watchdog, and holds
// the done/error status until the HPS completes a four-phase acknowledge.
module tpu_hps_job_ctrl
  import tpu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hps_start,
  input  logic             hps_ack,
  input  logic             tpu_done,
  output logic             tpu_start,
  output logic             busy,
  output logic             done_to_hps,
  output logic             err_to_hps,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic start_rise;

  logic [STATE_W-1:0] state_q,       state_d;
  logic [CNT_W-1:0]   run_cnt_q,     run_cnt_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic               tpu_start_q,   tpu_start_d;
  logic               busy_q,        busy_d;
  logic [STAT_W-1:0]  status_q,      status_d;
  logic [CNT_W-1:0]   run_inc;

  rise_edge_det u_start_edge (
    .clk   (clk),
    .rst_n (reset_n),
    .din   (hps_start),
    .rise  (start_rise)
  );

  // Next state, counters, and outputs decoded from the next state so that
  // every output register lines up with the state it belongs to.
  always_comb begin
    state_d       = state_q;
    run_cnt_d     = run_cnt_q;
    cycle_count_d = cycle_count_q;
    run_inc       = run_cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start_rise) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        run_cnt_d = '0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        run_cnt_d = run_inc;
        // A completion coinciding with the watchdog expiry counts as done.
        if (tpu_done) begin
          cycle_count_d = run_inc;
          state_d       = ST_DONE;
        end else if (run_inc == TIMEOUT_VAL) begin
          cycle_count_d = TIMEOUT_VAL;
          state_d       = ST_ERROR;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (hps_ack) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!hps_ack && !hps_start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    tpu_start_d         = (state_d == ST_LAUNCH);
    busy_d              = (state_d == ST_LAUNCH) || (state_d == ST_RUN);
    status_d            = '0;
    status_d[STAT_DONE] = (state_d == ST_DONE) || (state_d == ST_ERROR);
    status_d[STAT_ERR]  = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      run_cnt_q     <= '0;
      cycle_count_q <= '0;
      tpu_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      status_q      <= '0;
    end else begin
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      cycle_count_q <= cycle_count_d;
      tpu_start_q   <= tpu_start_d;
      busy_q        <= busy_d;
      status_q      <= status_d;
    end
  end

  assign tpu_start   = tpu_start_q;
  assign busy        = busy_q;
  assign done_to_hps = status_q[STAT_DONE];
  assign err_to_hps  = status_q[STAT_ERR];
  assign cycle_count = cycle_count_q;

endmodule : tpu_hps_job_ctrl
